// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: field widths, limits and FSM states.
package router_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned LEN_W = 6;
    localparam int unsigned MAX_LEN = 63;
    localparam logic [ADDR_W-1:0] DEST_INVALID = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StHeader,
        StPayload,
        StParity,
        StWait
    } tx_state_e;

    // Header beat layout on the router wire: length in the upper bits, destination below.
    function automatic logic [7:0] make_header(input logic [LEN_W-1:0] l,
                                               input logic [ADDR_W-1:0] d);
        return {l, d};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: one synchronous write port, one combinational read port.
module router_tx_buf #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a whole payload, then sends header, payload and parity
// beats on the router din/pkt_valid interface, stalling header/payload beats on busy.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest,
    input  logic [LEN_W-1:0]  len,
    output logic              req_ready,
    output logic              req_rej,
    input  logic [7:0]        pld_data,
    input  logic              pld_valid,
    output logic              pld_ready,
    output logic [7:0]        din,
    output logic              pkt_valid,
    input  logic              busy,
    input  logic              err,
    output logic              done,
    output logic              done_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tx_state_e state_q, state_d;

    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]        par_q, par_d;
    logic [7:0]        din_q, din_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic              done_q, done_d;
    logic              done_err_q, done_err_d;
    logic              req_rej_q, req_rej_d;

    logic              buf_we;
    logic [AW-1:0]     buf_waddr;
    logic [AW-1:0]     buf_raddr;
    logic [7:0]        buf_rdata;
    logic [LEN_W-1:0]  last_idx;
    logic              req_legal;

    assign last_idx  = len_q - LEN_W'(1);
    assign req_legal = (len != '0) && (dest != DEST_INVALID);
    assign buf_waddr = AW'(cnt_q);

    router_tx_buf #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_buf (
        .clk  (clk),
        .we   (buf_we),
        .waddr(buf_waddr),
        .wdata(pld_data),
        .raddr(buf_raddr),
        .rdata(buf_rdata)
    );

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        par_d       = par_q;
        din_d       = din_q;
        pkt_valid_d = pkt_valid_q;
        done_d      = 1'b0;
        done_err_d  = done_err_q;
        req_rej_d   = 1'b0;
        buf_we      = 1'b0;
        // Look one byte ahead so the consuming edge can load the next beat directly.
        buf_raddr   = AW'(rd_ptr_q + LEN_W'(1));

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (req_legal) begin
                        dest_d     = dest;
                        len_d      = len;
                        cnt_d      = '0;
                        par_d      = '0;
                        done_err_d = 1'b0;
                        state_d    = StFill;
                    end else begin
                        req_rej_d = 1'b1;
                    end
                end
            end
            StFill: begin
                if (pld_valid) begin
                    buf_we = 1'b1;
                    par_d  = par_q ^ pld_data;
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (cnt_q == last_idx) begin
                        din_d       = make_header(len_q, dest_q);
                        pkt_valid_d = 1'b1;
                        state_d     = StHeader;
                    end
                end
            end
            StHeader: begin
                buf_raddr = '0;
                if (!busy) begin
                    par_d    = par_q ^ din_q;
                    rd_ptr_d = '0;
                    din_d    = buf_rdata;
                    state_d  = StPayload;
                end
            end
            StPayload: begin
                if (!busy) begin
                    if (rd_ptr_q == last_idx) begin
                        din_d       = par_q;
                        pkt_valid_d = 1'b0;
                        state_d     = StParity;
                    end else begin
                        rd_ptr_d = rd_ptr_q + LEN_W'(1);
                        din_d    = buf_rdata;
                    end
                end
            end
            StParity: begin
                // The router always captures parity here, so busy is ignored.
                din_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                done_err_d = done_err_q | err;
                if (!busy) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            dest_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            par_q       <= '0;
            din_q       <= '0;
            pkt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
            req_rej_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            par_q       <= par_d;
            din_q       <= din_d;
            pkt_valid_q <= pkt_valid_d;
            done_q      <= done_d;
            done_err_q  <= done_err_d;
            req_rej_q   <= req_rej_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign pld_ready = (state_q == StFill);
    assign din       = din_q;
    assign pkt_valid = pkt_valid_q;
    assign done      = done_q;
    assign done_err  = done_err_q;
    assign req_rej   = req_rej_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: randomized packets against a wire-level reference model.
module tb_router_pkt_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] dest;
    logic [5:0] len;
    logic       req_ready;
    logic       req_rej;
    logic [7:0] pld_data;
    logic       pld_valid;
    logic       pld_ready;
    logic [7:0] din;
    logic       pkt_valid;
    logic       busy;
    logic       err;
    logic       done;
    logic       done_err;

    router_pkt_tx #(
        .DEPTH(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dest     (dest),
        .len      (len),
        .req_ready(req_ready),
        .req_rej  (req_rej),
        .pld_data (pld_data),
        .pld_valid(pld_valid),
        .pld_ready(pld_ready),
        .din      (din),
        .pkt_valid(pkt_valid),
        .busy     (busy),
        .err      (err),
        .done     (done),
        .done_err (done_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (wire-level) ----------------
    int         m_mode = 0;  // 0 idle, 1 collecting payload, 2 on the wire, 3 waiting for done
    int         m_len;
    int         m_beat;
    logic [1:0] m_dest;
    logic [7:0] m_pl[$];
    logic [7:0] m_wire[$];
    logic [7:0] e_din = 8'h00;
    logic       e_pv = 1'b0, e_done = 1'b0, e_derr = 1'b0, e_rej = 1'b0;
    bit         m_valid = 1'b0;

    // Effect of the coming rising edge given the inputs presented now.
    task automatic model_step();
        logic [7:0] p;
        if (rst) begin
            m_mode = 0;
            e_din = 8'h00; e_pv = 1'b0; e_done = 1'b0; e_derr = 1'b0; e_rej = 1'b0;
            m_valid = 1'b1;
            return;
        end
        e_done = 1'b0;
        e_rej  = 1'b0;
        case (m_mode)
            0: if (start) begin
                if (len != 0 && dest != 2'd3) begin
                    m_mode = 1; m_len = int'(len); m_dest = dest;
                    m_pl.delete();
                    e_derr = 1'b0;
                end else begin
                    e_rej = 1'b1;
                end
            end
            1: if (pld_valid) begin
                m_pl.push_back(pld_data);
                if (m_pl.size() == m_len) begin
                    m_wire.delete();
                    m_wire.push_back(8'(m_len * 4 + int'(m_dest)));
                    p = m_wire[0];
                    foreach (m_pl[k]) begin
                        m_wire.push_back(m_pl[k]);
                        p = p ^ m_pl[k];
                    end
                    m_wire.push_back(p);
                    m_mode = 2; m_beat = 0;
                    e_din = m_wire[0]; e_pv = 1'b1;
                end
            end
            2: if (m_beat == m_len + 1) begin
                e_din = 8'h00; m_mode = 3;
            end else if (!busy) begin
                m_beat++;
                e_din = m_wire[m_beat];
                e_pv  = (m_beat <= m_len);
            end
            3: begin
                if (err) e_derr = 1'b1;
                if (!busy) begin
                    e_done = 1'b1; m_mode = 0;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    logic [7:0] cap[$];
    bit         cap_prev_pv = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("din", din, e_din);
            chk("pkt_valid", pkt_valid, e_pv);
            chk("done", done, e_done);
            chk("done_err", done_err, e_derr);
            chk("req_rej", req_rej, e_rej);
            chk("req_ready", req_ready, m_mode == 0);
            chk("pld_ready", pld_ready, m_mode == 1);
        end
        if (pkt_valid === 1'b1 || cap_prev_pv) cap.push_back(din);
        cap_prev_pv = (pkt_valid === 1'b1);
        model_step();
    end

    // ---------------- stimulus ----------------
    logic [7:0] pl[64];
    int         t_start, t_hdr, t_done;
    logic       last_done_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 no busy, 1 random busy/err/stray start, 2 stall on 0x22, 3 err capture,
    //       4 reset after the second payload beat
    task automatic send(input logic [1:0] d, input logic [5:0] l, input int mode, input bit gaps);
        int  i, guard, ep, stall_left, pvcnt;
        bit  acc, pv_prev, got_done, stalled, aborted;
        start = 1'b1; dest = d; len = l;
        tick();
        t_start = cycle;
        start = 1'b0;
        i = 0; guard = 0;
        while (i < int'(l) && guard < 2000) begin
            pld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            pld_data  = pl[i];
            if (mode == 1) begin
                busy  = $urandom_range(0, 1) == 1;
                err   = $urandom_range(0, 1) == 1;
                start = $urandom_range(0, 3) == 0;
                dest  = 2'($urandom_range(0, 3));
                len   = 6'($urandom_range(0, 63));
            end
            acc = pld_valid && pld_ready;
            tick();
            guard++;
            if (acc) i++;
        end
        chk("fill_in_time", guard < 2000, 1);
        pld_valid = 1'b0; start = 1'b0; busy = 1'b0; err = 1'b0;
        pv_prev = 1'b0; ep = 0; stall_left = 0; stalled = 1'b0; pvcnt = 0;
        got_done = 1'b0; aborted = 1'b0; guard = 0; t_hdr = -1; t_done = -1;
        while (!got_done && !aborted && guard < 3000) begin
            if (pkt_valid) begin
                pvcnt++;
                if (t_hdr < 0) t_hdr = cycle - t_start;
            end
            if (mode == 3 && ep == 0 && pv_prev && !pkt_valid) ep = 1;
            pv_prev = pkt_valid;
            case (mode)
                1: begin
                    busy  = $urandom_range(0, 2) == 0;
                    err   = $urandom_range(0, 4) == 0;
                    start = !req_ready && ($urandom_range(0, 3) == 0);
                end
                2: begin
                    if (!stalled && pkt_valid && din == 8'h22) begin
                        stall_left = 3; stalled = 1'b1;
                    end
                    busy = stall_left > 0;
                    if (stall_left > 0) stall_left--;
                end
                3: if (ep > 0) begin
                    busy = ep < 4;
                    err  = ep == 2;
                    ep++;
                end
                4: if (pvcnt == 3) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    aborted = 1'b1;
                end
                default: begin
                    busy = 1'b0; err = 1'b0;
                end
            endcase
            if (!aborted) begin
                tick();
                guard++;
                if (done) begin
                    got_done = 1'b1;
                    last_done_err = done_err;
                    t_done = cycle - t_start;
                end
            end
        end
        start = 1'b0; busy = 1'b0; err = 1'b0;
        if (mode == 4) begin
            chk("rst_pkt_valid", pkt_valid, 0);
            chk("rst_din", din, 0);
            chk("rst_req_ready", req_ready, 1);
            chk("rst_no_done", done, 0);
        end else begin
            chk("done_in_time", got_done, 1);
        end
    endtask

    task automatic reject(input logic [1:0] d, input logic [5:0] l);
        start = 1'b1; dest = d; len = l;
        tick();
        start = 1'b0;
        chk("rej_pulse", req_rej, 1);
        chk("rej_req_ready", req_ready, 1);
        chk("rej_pkt_valid", pkt_valid, 0);
        chk("rej_pld_ready", pld_ready, 0);
    endtask

    logic [7:0] nom_exp[5];
    logic [7:0] stall_exp[8];

    initial begin
        nom_exp   = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        stall_exp = '{8'h0D, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h0D};
        rst = 1'b1; start = 1'b0; dest = 2'd0; len = 6'd0;
        pld_data = 8'h00; pld_valid = 1'b0; busy = 1'b0; err = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_req_ready", req_ready, 1);
        chk("reset_pld_ready", pld_ready, 0);
        chk("reset_pkt_valid", pkt_valid, 0);
        chk("reset_din", din, 0);
        chk("reset_done_err", done_err, 0);

        // Nominal packet
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        cap.delete();
        send(2'd1, 6'd3, 0, 1'b0);
        chk("nom_wire_len", cap.size(), 5);
        foreach (nom_exp[k]) chk("nom_wire_byte", (k < cap.size()) ? cap[k] : 8'hxx, nom_exp[k]);
        chk("nom_model_hdr", m_wire[0], 8'h0D);
        chk("nom_model_par", m_wire[4], 8'h0D);
        chk("nom_hdr_latency", t_hdr, 3);
        chk("nom_done_latency", t_done, 9);
        chk("nom_done_err", last_done_err, 0);

        // Stall while 0x22 is presented
        cap.delete();
        send(2'd1, 6'd3, 2, 1'b0);
        chk("stall_wire_len", cap.size(), 8);
        foreach (stall_exp[k])
            chk("stall_wire_byte", (k < cap.size()) ? cap[k] : 8'hxx, stall_exp[k]);

        // Illegal requests
        reject(2'd1, 6'd0);
        reject(2'd3, 6'd5);
        tick();
        chk("rej_no_repeat", req_rej, 0);

        // Maximum length
        for (int i = 0; i < 63; i++) pl[i] = 8'(i);
        cap.delete();
        send(2'd0, 6'd63, 0, 1'b0);
        chk("max_wire_len", cap.size(), 65);
        chk("max_hdr", (cap.size() > 0) ? cap[0] : 8'hxx, 8'hFC);
        chk("max_par", (cap.size() > 64) ? cap[64] : 8'hxx, 8'hC3);
        chk("max_model_len", m_wire.size(), 65);
        chk("max_model_par", m_wire[64], 8'hC3);
        chk("max_done_latency", t_done, 129);

        // Reset mid-payload, then a clean packet
        for (int i = 0; i < 5; i++) pl[i] = 8'($urandom);
        send(2'd2, 6'd5, 4, 1'b0);
        tick();
        chk("rst_still_no_done", done, 0);
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        cap.delete();
        send(2'd1, 6'd3, 0, 1'b0);
        chk("post_rst_wire_len", cap.size(), 5);
        chk("post_rst_par", (cap.size() > 4) ? cap[4] : 8'hxx, 8'h0D);

        // Error capture in WAIT
        send(2'd1, 6'd3, 3, 1'b0);
        chk("err_done_err", last_done_err, 1);
        tick();
        chk("err_sticky", done_err, 1);
        send(2'd2, 6'd2, 0, 1'b1);
        chk("err_cleared", last_done_err, 0);

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) reject(2'($urandom_range(0, 3)), 6'd0);
                else reject(2'd3, 6'($urandom_range(0, 63)));
            end else begin
                logic [5:0] l;
                l = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 8))
                                                : 6'($urandom_range(1, 63));
                for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
                send(2'($urandom_range(0, 2)), l, int'($urandom_range(0, 1)),
                     $urandom_range(0, 1) == 1);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the 1x3 router's input port. It accepts a transmit request (destination, payload length) plus a payload byte stream and buffers the whole payload. It then drives the router's `din`/`pkt_valid` protocol: a header beat, then payload beats, then a parity beat, stalling on `busy`. Verification environments use it as the stimulus source, and the multi-router fabric uses it as the upstream sender.

## Interface
Parameters:
- `DEPTH`, 64: payload buffer entries; must be ≥ `MAX_LEN`+1.

Ports:
- `clk`  in  1  rising-edge clock, single domain
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request strobe; accepted only when `req_ready`=1
- `dest`  in  2  destination port 0..2; 3 is illegal
- `len`  in  6  payload length 1..63; 0 is illegal
- `req_ready`  out  1  high in IDLE only
- `req_rej`  out  1  1-cycle pulse: illegal request dropped
- `pld_data`  in  8  payload byte
- `pld_valid`  in  1  payload byte valid
- `pld_ready`  out  1  high in FILL only
- `din`  out  8  byte to router
- `pkt_valid`  out  1  router packet-valid
- `busy`  in  1  router busy; stalls header/payload beats
- `err`  in  1  router parity-error flag
- `done`  out  1  1-cycle pulse: packet finished
- `done_err`  out  1  `err` seen during WAIT; valid with `done`

## Operation
- States: IDLE → FILL → HEADER → PAYLOAD → PARITY → WAIT → IDLE.
- **IDLE**
  - `start` with `len`≠0 and `dest`≠3: latch `dest`/`len`, clear `cnt` (6b) and `par` (8b), go to FILL.
  - Illegal `start`: pulse `req_rej`, stay in IDLE.
- **FILL**: each `pld_valid`&`pld_ready` edge writes `buf[cnt]`, XORs the byte into `par`, and increments `cnt`. The edge that writes byte `len`-1 moves to HEADER and loads `din`={len,dest} with `pkt_valid`=1.
- **Beat rule** (HEADER/PAYLOAD): the presented beat is held stable. It is consumed at a rising edge where `busy`=0. On consumption the next beat is loaded; otherwise nothing changes.
- **HEADER consumed**: XOR the header into `par`, reset the read pointer, load `buf[0]`, go to PAYLOAD.
- **PAYLOAD**: byte i is consumed, then byte i+1 is loaded. On consuming byte `len`-1: load `din`=`par`, `pkt_valid`=0, go to PARITY.
- **PARITY**: held for exactly one cycle regardless of `busy`, because the router always captures parity in that cycle. Then `din`=0 and go to WAIT.
- **WAIT**
  - Any cycle with `err`=1 sets the sticky `done_err`.
  - The first edge with `busy`=0 pulses `done` and goes to IDLE.
  - `done_err` is cleared on the next accepted `start`.
- Parity = header XOR all payload bytes, 8-bit, no carry.
- `cnt` never wraps: max `len` 63 fits 6 bits with terminal compare `cnt==len-1`.
- `start` outside IDLE is ignored, with no `req_rej`.
- A `pld_valid` gap in FILL just waits, so the router-side stream is gap-free by construction.

## Timing
- All outputs are registered except `req_ready` and `pld_ready`, which decode directly from the state register.
- Reset values:
  - `din`=0, `pkt_valid`=0, `done`=0, `done_err`=0, `req_rej`=0.
  - State IDLE, so `req_ready`=1 and `pld_ready`=0.
  - Buffer contents are don't-care.
- `rst` mid-packet: the next edge forces IDLE, `pkt_valid`=0 and `din`=0. The packet is discarded and no `done` is issued.
- With no `busy` and `pld_valid` held high:
  - `start` at edge E0 leads to the header visible after edge E0+`len`.
  - The wire occupies `len`+2 cycles (header, `len` payload beats, parity).
  - `done` pulses at E0+2·`len`+3 if `busy` is low in WAIT.
- `busy` during PARITY has no effect. `busy` stuck high holds WAIT indefinitely.

## Structure
- Shared `router_pkg`: `ADDR_W`=2, `LEN_W`=6, `MAX_LEN`=63, `DEST_INVALID`=2'b11, and the transmitter state enum.
- Sub-module `router_tx_buf`: `DEPTH`x8 register array with one synchronous write port and one read port.
  - The read is combinational from the pointer, so PAYLOAD loads the next byte in the consuming cycle.
- Top: FSM, counters, parity register, output registers.

## Test plan
- Nominal packet:
  - Stimulus: `dest`=1, `len`=3, payload 0x11/0x22/0x33, `busy`=0.
  - Required response: `din` sequence 0x0D(`pkt_valid`=1), 0x11, 0x22, 0x33, then 0x0D with `pkt_valid`=0. `done`=1, `done_err`=0.
- Stall:
  - Stimulus: same packet, `busy`=1 for 3 cycles while 0x22 is presented.
  - Required response: 0x22 with `pkt_valid`=1 is held for 4 cycles total, then 0x33. Parity is still 0x0D.
- Illegal requests:
  - Stimulus: `start` with `len`=0, then `start` with `dest`=3.
  - Required response: `req_rej` pulses twice, state stays IDLE, `pkt_valid` stays 0, `pld_ready` stays 0.
- Maximum length:
  - Stimulus: `dest`=0, `len`=63, payload 0x00..0x3E.
  - Required response: header 0xFC, parity 0xC3, 65 wire cycles.
- Reset mid-payload:
  - Stimulus: `rst`=1 for one cycle after the second payload beat.
  - Required response: next cycle `pkt_valid`=0, `din`=0, `req_ready`=1, no `done`. A following packet is transmitted correctly.
- Error capture:
  - Stimulus: `err`=1 for one WAIT cycle, `busy` released 2 cycles later.
  - Required response: `done`=1 with `done_err`=1. `done_err` clears on the next accepted `start`.
